multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle MIPS control unit: a Moore state machine that sequences fetch, decode, address or execute, memory and write-back over 3–5 cycles per instruction. It drives the shared-datapath controls: PC, IR, register file, ALU source and op selects, and the single unified memory port. It extends the single-cycle decoder with:
- optional ADDI and BNE support;
- a memory-ready handshake;
- illegal-opcode trapping;
- an instruction-retire strobe.

## Interface
Parameters:
- OP_WIDTH, 6, opcode field width.
- EN_ADDI, 1, decode ADDI (0x08); when 0, ADDI is treated as illegal.
- EN_BNE, 1, decode BNE (0x05); when 0, BNE is treated as illegal.
- USE_MEM_READY, 1, stall memory states on mem_ready; when 0, mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; state → FETCH.
- Op  in  OP_WIDTH  opcode, IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite, PCWriteCond, BranchNE  out  1 each  PC update controls; BranchNE inverts the Zero test.
- IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite, RegDst, ALUSrcA  out  1 each.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unreachable; if entered, go to FETCH.

Per-state asserted outputs (every unlisted output is 0):
- FETCH: MemRead, ALUSrcB=01, IorD=0, PCSource=00; IRWrite and PCWrite = mem_ready. Stays in FETCH until mem_ready=1, then → DECODE.
- DECODE: ALUSrcB=11. Next state by opcode:
  - 0x00 → EXEC
  - 0x23 or 0x2B → MEMADR
  - 0x04 → BRANCH
  - 0x05 → BRANCH (if EN_BNE)
  - 0x02 → JUMP
  - 0x08 → ADDIEX (if EN_ADDI)
  - anything else → FETCH, with illegal_op=1.
- MEMADR: ALUSrcA, ALUSrcB=10. Op 0x23 → MEMRD; otherwise → MEMWR.
- MEMRD: MemRead, IorD. Held until mem_ready, then → MEMWB.
- MEMWB: RegWrite, MemToReg, instr_done. → FETCH.
- MEMWR: MemWrite, IorD; instr_done = mem_ready. Held until mem_ready, then → FETCH.
- EXEC: ALUSrcA, ALUOp=10. → RCOMP.
- RCOMP: RegDst, RegWrite, instr_done. → FETCH.
- BRANCH: ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01, instr_done; BranchNE=1 when Op=0x05. → FETCH.
- JUMP: PCWrite, PCSource=10, instr_done. → FETCH.
- ADDIEX: ALUSrcA, ALUSrcB=10, ALUOp=00. → ADDIWB.
- ADDIWB: RegWrite, RegDst=0, MemToReg=0, instr_done. → FETCH.

## Timing
- State register only; all outputs are combinational from state, Op and mem_ready. No other registers.
- While reset=1, all outputs are forced to 0 and state reads FETCH. The first FETCH outputs appear in the cycle after reset deasserts.
- Reset asserted mid-instruction aborts it immediately. No partial write is issued, because outputs are gated by reset.
- Cycle counts with mem_ready tied high: R-type 4, LW 5, SW 4, BEQ/BNE 3, J 3, ADDI 4, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. While stalled, outputs hold their values and IRWrite, PCWrite and instr_done stay 0.
- Op is sampled only in DECODE, MEMADR and BRANCH. Changes in Op during other states have no effect.

## Structure
- Shared package mips_ctrl_pkg contains:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI;
  - state enum ctrl_state_t (4-bit);
  - ALUOp and PCSource encodings.
- One combinational sub-module, mc_op_decode: Op plus enables → one-hot class {rtype, lw, sw, beq, bne, j, addi, illegal}.

## Test plan
- Reset mid-MEMRD, then release with mem_ready=1 → all outputs 0 during reset; FETCH outputs (MemRead=1, ALUSrcB=01) in the first post-reset cycle; no MemWrite or RegWrite at any point.
- Op=0x23, mem_ready=1 → states 0,1,2,3,4; RegWrite=MemToReg=1 in cycle 5; instr_done is high in cycle 5 only.
- Op=0x2B, mem_ready low for 3 cycles in MEMWR → MemWrite held for 4 cycles; instr_done pulses once, on the cycle mem_ready=1; then FETCH.
- Op=0x05 with EN_BNE=1 → BRANCH with PCWriteCond=1, BranchNE=1, ALUOp=01. Same opcode with EN_BNE=0 → illegal_op pulse in DECODE, then FETCH.
- Op=0x00 followed by Op=0x02 back-to-back → 4-cycle R-type sequence ending with RegDst=RegWrite=1, then a 3-cycle jump ending with PCWrite=1, PCSource=10.
- Op=0x3F → illegal_op=1 in DECODE; no RegWrite, MemWrite or PCWrite; next state FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, state
// encoding, datapath select encodings and the decoded instruction class.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RCOMP  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } ctrl_state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // One-hot instruction class produced by mc_op_decode
    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic addi;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/mc_op_decode.sv
// Opcode classifier: maps the opcode field to a one-hot instruction class,
// folding disabled optional instructions into the illegal class.
module mc_op_decode
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OP_WIDTH = 6,
    parameter bit          EN_ADDI  = 1'b1,
    parameter bit          EN_BNE   = 1'b1
) (
    input  logic [OP_WIDTH-1:0] op,
    output op_class_t           cls
);

    always_comb begin
        cls = '0;
        if (op == OP_WIDTH'(OP_RTYPE)) begin
            cls.rtype = 1'b1;
        end else if (op == OP_WIDTH'(OP_LW)) begin
            cls.lw = 1'b1;
        end else if (op == OP_WIDTH'(OP_SW)) begin
            cls.sw = 1'b1;
        end else if (op == OP_WIDTH'(OP_BEQ)) begin
            cls.beq = 1'b1;
        end else if (EN_BNE && (op == OP_WIDTH'(OP_BNE))) begin
            cls.bne = 1'b1;
        end else if (op == OP_WIDTH'(OP_J)) begin
            cls.j = 1'b1;
        end else if (EN_ADDI && (op == OP_WIDTH'(OP_ADDI))) begin
            cls.addi = 1'b1;
        end else begin
            cls.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: Moore sequencer for the shared datapath with
// memory-ready stalls, illegal-opcode trapping and a retire strobe.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OP_WIDTH      = 6,
    parameter bit          EN_ADDI       = 1'b1,
    parameter bit          EN_BNE        = 1'b1,
    parameter bit          USE_MEM_READY = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_WIDTH-1:0] Op,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BranchNE,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic [3:0]          state,
    output logic                instr_done,
    output logic                illegal_op
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    op_class_t   cls;
    logic        mem_ok;

    mc_op_decode #(
        .OP_WIDTH (OP_WIDTH),
        .EN_ADDI  (EN_ADDI),
        .EN_BNE   (EN_BNE)
    ) u_op_decode (
        .op  (Op),
        .cls (cls)
    );

    assign mem_ok = USE_MEM_READY ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                IRWrite  = mem_ok;
                PCWrite  = mem_ok;
                if (mem_ok) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                if (cls.rtype) begin
                    state_d = EXEC;
                end else if (cls.lw || cls.sw) begin
                    state_d = MEMADR;
                end else if (cls.beq || cls.bne) begin
                    state_d = BRANCH;
                end else if (cls.j) begin
                    state_d = JUMP;
                end else if (cls.addi) begin
                    state_d = ADDIEX;
                end else begin
                    state_d    = FETCH;
                    illegal_op = cls.illegal;
                end
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = cls.lw ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ok) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            // Store retires on the cycle the memory accepts it
            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ok;
                if (mem_ok) begin
                    state_d = FETCH;
                end
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = RCOMP;
            end
            RCOMP: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNE    = (Op == OP_WIDTH'(OP_BNE));
                instr_done  = 1'b1;
                state_d     = FETCH;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset gates every control so an aborted instruction issues no write
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            BranchNE    = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemToReg    = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SRCB_REG;
            ALUOp       = ALUOP_ADD;
            PCSource    = PCSRC_ALU;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign state = reset ? STATE_W'(FETCH) : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench: two control units (full-featured, and one
// with ADDI/BNE disabled and mem_ready ignored) against an instruction-level model.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset0, reset1;
    logic [5:0] op;
    logic       mem_ready;
    int         total = 0;
    int         bad   = 0;

    logic pcw0, pcwc0, bne0, iord0, mrd0, mwr0, irw0, m2r0, rw0, rdst0, srca0, done0, ill0;
    logic [1:0] srcb0, aop0, pcs0;
    logic [3:0] st0;
    logic pcw1, pcwc1, bne1, iord1, mrd1, mwr1, irw1, m2r1, rw1, rdst1, srca1, done1, ill1;
    logic [1:0] srcb1, aop1, pcs1;
    logic [3:0] st1;
    logic [22:0] obs0, obs1;

    always #5 clk = ~clk;

    multicycle_control_unit dut0 (
        .clk(clk), .reset(reset0), .Op(op), .mem_ready(mem_ready),
        .PCWrite(pcw0), .PCWriteCond(pcwc0), .BranchNE(bne0), .IorD(iord0),
        .MemRead(mrd0), .MemWrite(mwr0), .IRWrite(irw0), .MemToReg(m2r0),
        .RegWrite(rw0), .RegDst(rdst0), .ALUSrcA(srca0), .ALUSrcB(srcb0),
        .ALUOp(aop0), .PCSource(pcs0), .state(st0), .instr_done(done0),
        .illegal_op(ill0)
    );

    multicycle_control_unit #(
        .EN_ADDI(1'b0), .EN_BNE(1'b0), .USE_MEM_READY(1'b0)
    ) dut1 (
        .clk(clk), .reset(reset1), .Op(op), .mem_ready(mem_ready),
        .PCWrite(pcw1), .PCWriteCond(pcwc1), .BranchNE(bne1), .IorD(iord1),
        .MemRead(mrd1), .MemWrite(mwr1), .IRWrite(irw1), .MemToReg(m2r1),
        .RegWrite(rw1), .RegDst(rdst1), .ALUSrcA(srca1), .ALUSrcB(srcb1),
        .ALUOp(aop1), .PCSource(pcs1), .state(st1), .instr_done(done1),
        .illegal_op(ill1)
    );

    assign obs0 = {pcw0, pcwc0, bne0, iord0, mrd0, mwr0, irw0, m2r0, rw0, rdst0, srca0,
                   srcb0, aop0, pcs0, st0, done0, ill0};
    assign obs1 = {pcw1, pcwc1, bne1, iord1, mrd1, mwr1, irw1, m2r1, rw1, rdst1, srca1,
                   srcb1, aop1, pcs1, st1, done1, ill1};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic bit is_illegal(input logic [5:0] o, input bit en_addi, input bit en_bne);
        case (o)
            6'h00, 6'h23, 6'h2B, 6'h04, 6'h02: return 1'b0;
            6'h05:   return !en_bne;
            6'h08:   return !en_addi;
            default: return 1'b1;
        endcase
    endfunction

    // Cycles per instruction with memory always ready
    function automatic int spec_cycles(input logic [5:0] o, input bit en_addi, input bit en_bne);
        if (is_illegal(o, en_addi, en_bne)) return 2;
        case (o)
            6'h00:        return 4;
            6'h23:        return 5;
            6'h2B:        return 4;
            6'h04, 6'h05: return 3;
            6'h02:        return 3;
            default:      return 4;
        endcase
    endfunction

    // Expected control vector for one step of an instruction (step id = debug state code)
    function automatic logic [22:0] exp_out(input int ph, input logic [5:0] o, input bit r,
                                            input bit en_addi, input bit en_bne);
        logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rdst, srca, done, ill;
        logic [1:0] srcb, aop, pcs;
        {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rdst, srca, done, ill} = '0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (ph)
            0:  begin mrd = 1; srcb = 2'b01; irw = r; pcw = r; end
            1:  begin srcb = 2'b11; ill = is_illegal(o, en_addi, en_bne); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mwr = 1; iord = 1; done = r; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; done = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; bne = (o == 6'h05); end
            9:  begin pcw = 1; pcs = 2'b10; done = 1; end
            10: begin srca = 1; srcb = 2'b10; end
            11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rdst, srca,
                srcb, aop, pcs, 4'(ph), done, ill};
    endfunction

    // Runs one instruction on dut<sel>; called at posedge+1 with that unit in FETCH
    task automatic run_instr(input bit sel, input logic [5:0] o, input bit rnd,
                             input int stall_ph, input int nstall);
        int  steps[$];
        int  ph, cyc, waits, stall_total;
        bit  r, reff, en_addi, en_bne, use_rdy;
        en_addi = !sel; en_bne = !sel; use_rdy = !sel;
        steps = {0, 1};
        if (!is_illegal(o, en_addi, en_bne)) begin
            case (o)
                6'h00:        steps = {steps, 6, 7};
                6'h23:        steps = {steps, 2, 3, 4};
                6'h2B:        steps = {steps, 2, 5};
                6'h04, 6'h05: steps.push_back(8);
                6'h02:        steps.push_back(9);
                default:      steps = {steps, 10, 11};
            endcase
        end
        cyc = 0; waits = 0; stall_total = 0;
        while (steps.size() > 0) begin
            ph = steps[0];
            op = (ph == 1 || ph == 2 || ph == 8) ? o : 6'($urandom);
            r  = rnd ? (($urandom_range(0, 3) != 0) || waits >= 3) : 1'b1;
            if (ph == stall_ph && waits < nstall) r = 1'b0;
            mem_ready = r;
            reff = use_rdy ? r : 1'b1;
            @(negedge clk);
            check($sformatf("d%0d op%02h step%0d", sel, o, ph),
                  32'(sel ? obs1 : obs0), 32'(exp_out(ph, o, reff, en_addi, en_bne)));
            if (sel ? reset0 : reset1)
                check("held_in_reset", 32'(sel ? obs0 : obs1), 32'd0);
            cyc++;
            if ((ph == 0 || ph == 3 || ph == 5) && !reff) begin
                waits++;
                stall_total++;
            end else begin
                void'(steps.pop_front());
                waits = 0;
            end
            @(posedge clk); #1;
        end
        check($sformatf("cycles d%0d op%02h", sel, o), 32'(cyc),
              32'(spec_cycles(o, en_addi, en_bne) + stall_total));
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] legal [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
        if ($urandom_range(0, 4) == 0) return 6'($urandom);
        return legal[$urandom_range(0, 6)];
    endfunction

    initial begin
        reset0 = 1'b1; reset1 = 1'b1; op = 6'h23; mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_dut0", 32'(obs0), 32'd0);
            check("reset_dut1", 32'(obs1), 32'd0);
        end
        @(posedge clk); #1;
        reset0 = 1'b0;

        // Directed sequences on the full-featured unit
        run_instr(0, 6'h23, 0, -1, 0);
        run_instr(0, 6'h2B, 0, 5, 3);
        run_instr(0, 6'h05, 0, -1, 0);
        run_instr(0, 6'h04, 0, -1, 0);
        run_instr(0, 6'h00, 0, -1, 0);
        run_instr(0, 6'h02, 0, -1, 0);
        run_instr(0, 6'h3F, 0, -1, 0);
        run_instr(0, 6'h08, 0, -1, 0);
        run_instr(0, 6'h23, 0, 3, 2);
        run_instr(0, 6'h00, 0, 0, 2);

        for (int i = 0; i < 80; i++) run_instr(0, pick_op(), 1, -1, 0);

        // Abort a load in MEMRD with an asynchronous reset
        for (int s = 0; s < 3; s++) begin
            op = 6'h23; mem_ready = 1'b1;
            @(negedge clk);
            check($sformatf("pre_abort step%0d", s), 32'(obs0),
                  32'(exp_out(s, 6'h23, 1'b1, 1'b1, 1'b1)));
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("memrd_before_reset", 32'(obs0), 32'(exp_out(3, 6'h23, 1'b0, 1'b1, 1'b1)));
        #2 reset0 = 1'b1;
        #1 check("reset_async_gate", 32'(obs0), 32'd0);
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", 32'(obs0), 32'd0);
        end
        @(posedge clk); #1;
        reset0 = 1'b0;
        run_instr(0, 6'h23, 0, -1, 0);

        // Reduced unit: ADDI/BNE illegal, mem_ready ignored
        reset0 = 1'b1;
        reset1 = 1'b0;
        run_instr(1, 6'h05, 0, -1, 0);
        run_instr(1, 6'h08, 0, -1, 0);
        run_instr(1, 6'h2B, 0, 5, 3);
        run_instr(1, 6'h23, 0, 3, 2);
        for (int i = 0; i < 40; i++) run_instr(1, pick_op(), 1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
